nbit_sync_updown_mod: RTL
=========================

Name: nbit_sync_updown_mod

Overview:
Synchronous, fully parametrised up/down counter that replaces the ripple T-flip-flop counter style. All state changes on one clock edge. Adds:
- programmable modulus and clock-enable prescaler
- parallel load
- wrap or saturate selection
- terminal-count and wrap flags, plus a sticky overflow flag

Used as a general event/timebase counter in the examples library.

Parameters:
- N, 4, counter width in bits; N >= 2.
- MOD, 16, count range 0..MOD-1; 2 <= MOD <= 2^N.
- DIV, 1, prescale ratio: one count step per DIV enabled cycles; DIV >= 1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; the prescaler advances only when en=1.
- mode  input  1  direction: 1 = up, 0 = down.
- load  input  1  parallel load strobe.
- d  input  N  load value.
- sat  input  1  boundary policy: 1 = saturate, 0 = wrap.
- clr_ovf  input  1  clears the sticky overflow flag.
- y  output  N  counter value (registered).
- tc  output  1  terminal count indicator (combinational from y and mode).
- wrp  output  1  one-cycle boundary event pulse (registered).
- ovf  output  1  sticky overflow flag (registered).

Behaviour:
- Reset (rst=1 at clk edge): y=0, prescaler=0, wrp=0, ovf=0. Reset has highest priority over load, count and clr_ovf. Reset applied mid-count takes effect on that edge.
- Priority below reset: load > count.
- Load (load=1):
  - y <= d if d < MOD, else y <= MOD-1.
  - Prescaler <= 0. No tick occurs. wrp <= 0. ovf is unchanged, except that clr_ovf still applies.
  - Load is honoured regardless of en.
- Prescaler:
  - Internal counter pre, range 0..DIV-1, advances only on edges with en=1 and load=0.
  - tick = en & (pre == DIV-1). On a tick, pre <= 0; otherwise pre <= pre+1.
  - With DIV=1, every enabled cycle is a tick and pre is constant 0.
  - en=0 freezes pre and y.
- Count on tick:
  - Up (mode=1): if y < MOD-1, y <= y+1. At y == MOD-1: sat=0 gives y <= 0; sat=1 holds y.
  - Down (mode=0): if y > 0, y <= y-1. At y == 0: sat=0 gives y <= MOD-1; sat=1 holds y.
- Boundary event: a tick taken while tc=1 (whether it wraps or is saturation-blocked).
  - wrp <= 1 for exactly the next cycle; otherwise wrp <= 0.
  - ovf <= 1 on a boundary event. ovf stays 1 until an edge with clr_ovf=1 and no boundary event.
  - If a boundary event and clr_ovf occur on the same edge, set wins and ovf stays 1.
- tc = (mode & y == MOD-1) | (~mode & y == 0). Follows mode immediately, with no register.
- Mode or sat changes take effect at the next tick. Changing them does not reset the prescaler.
- y never leaves 0..MOD-1, including after a load of an out-of-range value.
- Arithmetic is performed at N+1 bits internally. No truncation artefacts occur when MOD = 2^N.

Test Plan:
1. N=4, MOD=10, DIV=1, reset then en=1, mode=1, sat=0 for 12 cycles -> y = 1,2,...,9,0,1,2. wrp high the cycle after y goes 9→0. ovf=1 afterwards. tc=1 while y=9.
2. Same configuration, mode=0 from y=0 -> y = 9,8,7; wrp pulses once. Then clr_ovf=1 for one cycle with no boundary event -> ovf=0.
3. MOD=10, sat=1, mode=1, load d=8, then 4 enabled cycles -> y = 8,9,9,9. wrp pulses after each blocked tick. ovf=1. Assert clr_ovf on an edge with a blocked tick -> ovf stays 1.
4. DIV=3, MOD=16, en=1, mode=1 -> y increments every 3rd cycle. Drop en for 2 cycles mid-prescale -> y and the phase are frozen. Resuming completes the same prescale period.
5. Load d=12 with MOD=10 -> y=9. Load asserted together with a would-be tick -> y=d, no count and no wrp. Load with en=0 -> still loads.
6. Assert rst mid-count at y=5 with ovf=1 and load=1 on the same edge -> y=0, ovf=0, wrp=0. MOD=16, N=4 up-count wraps 15→0 cleanly.

Source files
------------

// File: rtl/nbit_sync_updown_mod_if.sv
// Control and status bundle of the synchronous up/down modulus counter.
// The master side drives the controls and the slave (counter) side drives the status.
interface nbit_sync_updown_mod_if #(
    parameter int N = 4
);
    logic         en;
    logic         mode;
    logic         load;
    logic [N-1:0] d;
    logic         sat;
    logic         clr_ovf;
    logic [N-1:0] y;
    logic         tc;
    logic         wrp;
    logic         ovf;

    modport master (
        output en, mode, load, d, sat, clr_ovf,
        input  y, tc, wrp, ovf
    );

    modport slave (
        input  en, mode, load, d, sat, clr_ovf,
        output y, tc, wrp, ovf
    );
endinterface

// File: rtl/nbit_sync_updown_mod.sv
// Up/down counter over 0..MOD-1 with a DIV prescaler, parallel load, wrap/saturate policy,
// a registered boundary pulse and a sticky overflow flag. Every state change happens on the rising edge of clk.
module nbit_sync_updown_mod #(
    parameter int N   = 4,
    parameter int MOD = 16,
    parameter int DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    nbit_sync_updown_mod_if.slave      bus
);
    localparam int           PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    // N+1 bits keep MOD-1 and y+1 exact when MOD = 2^N.
    localparam logic [N:0]   TOP      = (N + 1)'(MOD - 1);

    logic [N-1:0]  cnt;
    logic [N-1:0]  cnt_nxt;
    logic [N-1:0]  load_val;
    logic [PW-1:0] pre;
    logic [N:0]    y_ext;
    logic          tc;
    logic          tick;
    logic          boundary;
    logic          wrp;
    logic          ovf;

    assign y_ext    = {1'b0, cnt};
    assign load_val = ({1'b0, bus.d} > TOP) ? TOP[N-1:0] : bus.d;

    always_comb begin
        tc       = bus.mode ? (y_ext == TOP) : (y_ext == '0);
        tick     = bus.en & (pre == PRE_LAST);
        boundary = tick & tc;
        cnt_nxt  = cnt;
        if (tick) begin
            if (bus.mode) begin
                if (y_ext < TOP)
                    cnt_nxt = N'(y_ext + 1'b1);
                else if (!bus.sat)
                    cnt_nxt = '0;
            end else begin
                if (y_ext != '0)
                    cnt_nxt = N'(y_ext - 1'b1);
                else if (!bus.sat)
                    cnt_nxt = TOP[N-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pre <= '0;
            wrp <= 1'b0;
            ovf <= 1'b0;
        end else if (bus.load) begin
            cnt <= load_val;
            pre <= '0;
            wrp <= 1'b0;
            if (bus.clr_ovf)
                ovf <= 1'b0;
        end else begin
            if (bus.en)
                pre <= tick ? '0 : pre + 1'b1;
            cnt <= cnt_nxt;
            wrp <= boundary;
            // A boundary event on the same edge as clr_ovf keeps the flag set.
            if (boundary)
                ovf <= 1'b1;
            else if (bus.clr_ovf)
                ovf <= 1'b0;
        end
    end

    assign bus.y   = cnt;
    assign bus.tc  = tc;
    assign bus.wrp = wrp;
    assign bus.ovf = ovf;
endmodule
